// File: rtl/secure_memory_pkg.sv
// Shared types, constants and key derivation for the secure memory responder.
// Build option: SECURE_MEMORY_ADDR_TWEAK_EN selects per-word rotated storage keys.
package secure_memory_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic [31:0] DEFAULT_STORE_KEY = 32'h3C6E_A917;
    localparam int          ERR_COUNT_W       = 8;

`ifdef SECURE_MEMORY_ADDR_TWEAK_EN
    localparam bit TWEAK_EN = 1'b1;
`else
    localparam bit TWEAK_EN = 1'b0;
`endif

    // Storage key for one word: rotate-left by the low index bits when tweaking is built in.
    function automatic logic [31:0] key_for(input logic [31:0] key, input logic [4:0] rot);
        logic [63:0] dbl;
        logic [4:0]  amt;
        amt = TWEAK_EN ? rot : 5'd0;
        dbl = {key, key} << amt;
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/secure_memory_if.sv
// Avalon-MM style request/response bundle between the custom-instruction master and the secure memory.
interface secure_memory_if;
    import secure_memory_pkg::*;

    logic [31:0]            address;
    logic [3:0]             byteenable;
    logic                   chipselect;
    logic                   write;
    logic [31:0]            writedata;
    logic                   err_clear;
    logic [31:0]            readdata;
    logic                   waitrequest;
    logic                   init_done;
    logic                   err;
    logic [ERR_COUNT_W-1:0] err_count;

    modport master (
        output address, byteenable, chipselect, write, writedata, err_clear,
        input  readdata, waitrequest, init_done, err, err_count
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, err_clear,
        output readdata, waitrequest, init_done, err, err_count
    );

endinterface

// File: rtl/secure_memory_ram.sv
// Single-port DEPTH x 32 word store with byte write enables and a registered,
// de-whitening read port (read key supplied by the caller).
module secure_memory_ram #(
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    input  logic              rd_en_i,
    input  logic              rd_zero_i,
    input  logic [31:0]       rd_key_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // The array is deliberately unreset; the owner zeroizes it after every reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'h0000_0000;
        end else if (rd_en_i) begin
            rdata_q <= rd_zero_i ? 32'h0000_0000 : (mem_q[addr_i] ^ rd_key_i);
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/secure_memory_slave.sv
// Secure-memory Avalon-MM responder: zeroize-on-reset FSM, address decode,
// storage whitening and sticky/saturating access-error tracking.
module secure_memory_slave
    import secure_memory_pkg::*;
#(
    parameter  int          DEPTH     = 256,
    parameter  logic [31:0] STORE_KEY = DEFAULT_STORE_KEY,
    localparam int          ADDR_W    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    secure_memory_if.slave s_if
);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic                   wait_q, wait_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [ERR_COUNT_W-1:0] cnt_q, cnt_d;

    logic [ADDR_W-1:0]      idx_s;
    logic                   bad_s;
    logic                   access_s;
    logic [ADDR_W-1:0]      ram_addr_s;
    logic [31:0]            key_s;
    logic [3:0]             ram_be_s;
    logic [31:0]            ram_wdata_s;
    logic                   ram_rd_en_s;
    logic                   ram_rd_zero_s;
    logic [31:0]            ram_rdata_s;

    assign idx_s      = s_if.address[ADDR_W+1:2];
    assign bad_s      = (s_if.address[1:0] != 2'b00) || (|s_if.address[31:ADDR_W+2]);
    assign access_s   = s_if.chipselect && !wait_q;
    assign ram_addr_s = (state_q == INIT) ? ptr_q : idx_s;
    assign key_s      = key_for(STORE_KEY, 5'(ram_addr_s));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    state_d = INIT;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Handshake outputs are registered copies of the next state.
    always_comb begin
        wait_d = (state_d == INIT);
        done_d = (state_d == READY);
    end

    // Storage port: wipe during INIT, otherwise decoded, error-gated host accesses.
    always_comb begin
        ram_be_s      = 4'h0;
        ram_wdata_s   = 32'h0000_0000;
        ram_rd_en_s   = 1'b0;
        ram_rd_zero_s = 1'b0;
        if (state_q == INIT) begin
            ram_be_s    = 4'hF;
            ram_wdata_s = key_s;
        end else if (access_s) begin
            if (s_if.write) begin
                if (!bad_s) begin
                    ram_be_s    = s_if.byteenable;
                    ram_wdata_s = s_if.writedata ^ key_s;
                end else begin
                    ram_be_s = 4'h0;
                end
            end else begin
                ram_rd_en_s   = 1'b1;
                ram_rd_zero_s = bad_s;
            end
        end else begin
            ram_be_s = 4'h0;
        end
    end

    // A coincident clear zeroes the count but the new error still raises the flag.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (access_s && bad_s) begin
            err_d = 1'b1;
        end else if (s_if.err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        if (s_if.err_clear) begin
            cnt_d = '0;
        end else if (access_s && bad_s && (cnt_q != {ERR_COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + ERR_COUNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            wait_q <= wait_d;
            done_q <= done_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    secure_memory_ram #(.DEPTH(DEPTH)) u_ram (
        .clk       (clk),
        .reset     (reset),
        .addr_i    (ram_addr_s),
        .be_i      (ram_be_s),
        .wdata_i   (ram_wdata_s),
        .rd_en_i   (ram_rd_en_s),
        .rd_zero_i (ram_rd_zero_s),
        .rd_key_i  (key_s),
        .rdata_o   (ram_rdata_s)
    );

    assign s_if.readdata    = ram_rdata_s;
    assign s_if.waitrequest = wait_q;
    assign s_if.init_done   = done_q;
    assign s_if.err         = err_q;
    assign s_if.err_count   = cnt_q;

endmodule
